// File: rtl/eth_tx_framer.sv
// eth_tx_framer
//   Wraps an upstream byte stream into an Ethernet frame on a GMII-style
//   byte interface. It adds the preamble, the SFD, zero padding up to
//   MIN_FRAME, and the CRC-32 FCS. It then enforces IFG_BYTES idle cycles
//   after every frame.
//
// Ports
//   clk          single clock, rising edge
//   rst          synchronous, active-high reset
//   inData       payload byte from upstream
//   inDataValid  inData valid
//   inDataLast   final payload byte (only meaningful with inDataValid)
//   inReady      byte taken on an edge where inDataValid && inReady
//   txData       transmit byte (registered)
//   txCtrl       transmit enable (registered)
//   txErr        transmit error / frame abort (registered)
//   txBusy       high whenever the framer is not idle
//
// Timing model: the state names the phase whose byte is loaded into the
// output register at the coming edge. The edge that samples inDataValid in
// IDLE therefore already loads the first 0x55. PAYLOAD is entered while
// 0xD5 is still on the wire, so the first payload byte follows the SFD
// with no gap.
module eth_tx_framer #(
    parameter int MIN_FRAME = 60,
    parameter int IFG_BYTES = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] inData,
    input  logic       inDataValid,
    input  logic       inDataLast,
    output logic       inReady,
    output logic [7:0] txData,
    output logic       txCtrl,
    output logic       txErr,
    output logic       txBusy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREAMBLE,
        S_SFD,
        S_PAYLOAD,
        S_PAD,
        S_FCS,
        S_IFG
    } state_t;

    localparam logic [7:0]  MIN_B    = 8'(MIN_FRAME);
    localparam logic [7:0]  IFG_LAST = 8'(IFG_BYTES - 1);
    // IDLE loads the first 0x55, so PREAMBLE only has to add six more.
    localparam logic [7:0]  PRE_LAST = 8'd5;
    localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_POLY = 32'hEDB8_8320;

    state_t      r_state, w_state_nx;
    logic [7:0]  r_cnt,   w_cnt_nx;     // payload + pad bytes, saturating
    logic [7:0]  r_idx,   w_idx_nx;     // position within preamble / FCS / IFG
    logic [31:0] r_crc,   w_crc_nx;
    logic [7:0]  r_txData, w_txData_nx;
    logic        r_txCtrl, w_txCtrl_nx;
    logic        r_txErr,  w_txErr_nx;

    logic [7:0]  w_crc_in;
    logic [31:0] w_crc_upd;
    logic [7:0]  w_cnt_inc;
    logic [31:0] w_fcs;
    logic [7:0]  w_fcs_byte;

    // One byte of reflected CRC-32, LSB of the byte first.
    function automatic logic [31:0] f_crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
        end
        return r;
    endfunction

    // Pad bytes are zero. The CRC folds in whatever byte is loaded this
    // cycle. PAYLOAD and PAD are the only states that commit the result.
    assign w_crc_in  = (r_state == S_PAYLOAD) ? inData : 8'h00;
    assign w_crc_upd = f_crc_byte(r_crc, w_crc_in);

    // Saturation means anything of 255 bytes or more is "long enough", so
    // it only ever influences the pad decision.
    assign w_cnt_inc = (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;

    assign w_fcs = ~r_crc;

    always_comb begin
        w_fcs_byte = w_fcs[7:0];
        case (r_idx[1:0])
            2'd0:    w_fcs_byte = w_fcs[7:0];
            2'd1:    w_fcs_byte = w_fcs[15:8];
            2'd2:    w_fcs_byte = w_fcs[23:16];
            default: w_fcs_byte = w_fcs[31:24];
        endcase
    end

    always_comb begin
        w_state_nx  = r_state;
        w_cnt_nx    = r_cnt;
        w_idx_nx    = r_idx;
        w_crc_nx    = r_crc;
        w_txData_nx = 8'h00;
        w_txCtrl_nx = 1'b0;
        w_txErr_nx  = 1'b0;

        case (r_state)
            S_IDLE: begin
                // The first byte stays on inData; it is taken in PAYLOAD.
                if (inDataValid) begin
                    w_state_nx  = S_PREAMBLE;
                    w_cnt_nx    = 8'd0;
                    w_idx_nx    = 8'd0;
                    w_crc_nx    = CRC_INIT;
                    w_txData_nx = 8'h55;
                    w_txCtrl_nx = 1'b1;
                end
            end

            S_PREAMBLE: begin
                w_txData_nx = 8'h55;
                w_txCtrl_nx = 1'b1;
                if (r_idx == PRE_LAST) begin
                    w_state_nx = S_SFD;
                    w_idx_nx   = 8'd0;
                end else begin
                    w_idx_nx = r_idx + 8'd1;
                end
            end

            S_SFD: begin
                w_txData_nx = 8'hD5;
                w_txCtrl_nx = 1'b1;
                w_state_nx  = S_PAYLOAD;
            end

            S_PAYLOAD: begin
                w_txCtrl_nx = 1'b1;
                if (inDataValid) begin
                    w_txData_nx = inData;
                    w_crc_nx    = w_crc_upd;
                    w_cnt_nx    = w_cnt_inc;
                    if (inDataLast) begin
                        w_idx_nx = 8'd0;
                        if (w_cnt_inc < MIN_B) begin
                            w_state_nx = S_PAD;
                        end else begin
                            w_state_nx = S_FCS;
                        end
                    end
                end else begin
                    // Upstream ran dry mid-frame: poison the frame and go
                    // straight to the gap. No pad and no FCS are sent.
                    w_txErr_nx = 1'b1;
                    w_state_nx = S_IFG;
                    w_idx_nx   = 8'd0;
                end
            end

            S_PAD: begin
                w_txCtrl_nx = 1'b1;
                w_crc_nx    = w_crc_upd;
                w_cnt_nx    = w_cnt_inc;
                if (w_cnt_inc == MIN_B) begin
                    w_state_nx = S_FCS;
                    w_idx_nx   = 8'd0;
                end
            end

            S_FCS: begin
                w_txData_nx = w_fcs_byte;
                w_txCtrl_nx = 1'b1;
                if (r_idx == 8'd3) begin
                    w_state_nx = S_IFG;
                    w_idx_nx   = 8'd0;
                end else begin
                    w_idx_nx = r_idx + 8'd1;
                end
            end

            S_IFG: begin
                // Every IFG cycle loads an idle byte. Leaving after
                // IFG_BYTES cycles lets IDLE sample a waiting frame on the
                // next edge. That keeps the wire gap at exactly IFG_BYTES.
                if (r_idx == IFG_LAST) begin
                    w_state_nx = S_IDLE;
                    w_idx_nx   = 8'd0;
                end else begin
                    w_idx_nx = r_idx + 8'd1;
                end
            end

            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= 8'd0;
            r_idx    <= 8'd0;
            r_crc    <= CRC_INIT;
            r_txData <= 8'h00;
            r_txCtrl <= 1'b0;
            r_txErr  <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_cnt    <= w_cnt_nx;
            r_idx    <= w_idx_nx;
            r_crc    <= w_crc_nx;
            r_txData <= w_txData_nx;
            r_txCtrl <= w_txCtrl_nx;
            r_txErr  <= w_txErr_nx;
        end
    end

    assign inReady = (r_state == S_PAYLOAD);
    assign txBusy  = (r_state != S_IDLE);
    assign txData  = r_txData;
    assign txCtrl  = r_txCtrl;
    assign txErr   = r_txErr;

endmodule

// File: doc/eth_tx_framer.md
ETH_TX_FRAMER -- requirements
Module: eth_tx_framer

Interface
REQ-001 SHALL have parameter MIN_FRAME, default 60, minimum payload+pad bytes before FCS (legal range 1..255).
REQ-002 SHALL have parameter IFG_BYTES, default 12, idle cycles after each frame (legal range 1..255).
REQ-003 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port inData  input  8  payload byte from upstream.
REQ-006 SHALL have port inDataValid  input  1  inData valid.
REQ-007 SHALL have port inDataLast  input  1  marks final payload byte; qualified by inDataValid.
REQ-008 SHALL have port inReady  output  1  byte accepted on edge where inDataValid && inReady.
REQ-009 SHALL have port txData  output  8  byte to GMII/RGMII TX path.
REQ-010 SHALL have port txCtrl  output  1  transmit enable.
REQ-011 SHALL have port txErr  output  1  transmit error, frame abort.
REQ-012 SHALL have port txBusy  output  1  high in every state except IDLE.

Function
REQ-013 SHALL implement states IDLE, PREAMBLE, SFD, PAYLOAD, PAD, FCS, IFG.
REQ-014 IDLE: inReady=0, txCtrl=0, txData=0x00; inDataValid=1 -> PREAMBLE; the first payload byte is held, not consumed.
REQ-015 PREAMBLE: 7 cycles of txData=0x55, txCtrl=1, then SFD; SFD: 1 cycle of txData=0xD5, txCtrl=1, then PAYLOAD.
REQ-016 Outputs SHALL be registered; first 0x55 appears the cycle after the edge that sampled inDataValid=1 in IDLE.
REQ-017 PAYLOAD: inReady=1; each accepted byte appears on txData with txCtrl=1 one cycle after acceptance (registered).
REQ-018 An 8-bit byte counter SHALL count payload+pad bytes, saturating at 255, cleared on entry to PREAMBLE.
REQ-019 Accepted byte with inDataLast=1: -> PAD if count (including this byte) < MIN_FRAME, else -> FCS; inReady drops the following cycle.
REQ-020 PAD: transmit 0x00 until count == MIN_FRAME, then -> FCS.
REQ-021 CRC SHALL be IEEE 802.3 CRC-32 (reflected poly 0xEDB88320, init 0xFFFFFFFF, final bitwise complement) over payload and pad bytes only.
REQ-022 FCS: 4 cycles, txCtrl=1, complemented CRC sent least-significant byte first, then -> IFG.
REQ-023 IFG: txCtrl=0, txData=0x00, inReady=0 for IFG_BYTES cycles, then -> IDLE; inDataValid during IFG is ignored.
REQ-024 Underrun: in PAYLOAD with inDataValid=0 and no last byte yet accepted -> drive txCtrl=1, txErr=1, txData=0x00 for one cycle, then -> IFG; no PAD/FCS.
REQ-025 txErr SHALL be 0 in all cycles except the underrun cycle.
REQ-026 inDataLast with inDataValid=0 SHALL be ignored.
REQ-027 Payload longer than 255 bytes is permitted; counter saturation SHALL only affect the pad decision.
REQ-028 Back-to-back frames: a valid byte presented on the last IFG cycle SHALL be seen in IDLE on the next cycle; minimum gap is exactly IFG_BYTES txCtrl=0 cycles.

Reset
REQ-029 rst=1 SHALL force state IDLE, counters 0, CRC 0xFFFFFFFF, txData=0x00, txCtrl=0, txErr=0, inReady=0, txBusy=0 at the next edge.
REQ-030 rst asserted mid-frame SHALL abort immediately without txErr; the next frame starts from PREAMBLE with no IFG owed.

Verification
REQ-031 MIN_FRAME=9; payload ASCII "123456789" with last on '9' -> txData 7x0x55, 0xD5, 31..39, then 0x26 0x39 0xF4 0xCB; txCtrl high exactly 21 cycles.
REQ-032 Default params; 1-byte payload 0xAB -> 0xAB then 59x0x00, 4 FCS bytes matching reference CRC model; 72 txCtrl cycles, then 12 idle cycles.
REQ-033 Two 64-byte frames, second presented continuously -> exactly 12 txCtrl=0 cycles between the last FCS byte and the next 0x55.
REQ-034 inDataValid dropped after 10 payload bytes -> one cycle txCtrl=1, txErr=1, then 12 idle cycles, no FCS, then IDLE.
REQ-035 rst pulsed during the 3rd FCS byte -> next cycle txCtrl=0, txBusy=0; new frame afterwards starts with 0x55 and has a correct FCS.
REQ-036 300-byte payload -> no pad, all 300 bytes passed through in order, FCS matches reference model.
